fp_divider_seq: RTL and testbench
=================================

// Module: fp_divider_seq
// PURPOSE
// - Sequential IEEE-754 single-precision divider: q = a / b. Inverse operation of the combinational
//   floating_point_multiplier in the light_nn datapath.
// - Used by the normalisation/softmax path. Operands enter via valid/ready; result leaves via valid/ready.
// - Mantissa quotient from restoring division, one quotient bit per clock.
// PARAMETERS
// - QNAN  32'h7FC0_0000  value emitted for every invalid operation (0/0, inf/inf, any NaN operand)
// PORTS
// - clk        input   1   rising-edge clock
// - rst_n      input   1   asynchronous active-low reset
// - in_valid   input   1   a/b valid
// - in_ready   output  1   high only in IDLE; transfer when in_valid & in_ready at a rising edge
// - a          input   32  dividend, IEEE-754 single
// - b          input   32  divisor, IEEE-754 single
// - out_valid  output  1   q valid; held until out_ready
// - out_ready  input   1   consumer accepts q when out_valid & out_ready
// - q          output  32  quotient, IEEE-754 single
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, q=32'h0, all internal regs=0.
// - Reset mid-operation aborts the division; no result is produced for the aborted operands.
// - FSM: IDLE -> (accept, special case) DONE | (accept, normal) DIVIDE;
//   DIVIDE (25 cycles, down-counter) -> NORM -> DONE; DONE -> IDLE when out_ready.
// - Operands are registered on accept. Changes on a/b after acceptance have no effect.
// - Sign = a[31]^b[31] for every result, including zero and inf. QNAN output has sign 0.
// - Denormal inputs are flushed to zero (exp==0 -> treated as signed zero).
// - Special cases (resolved in the accept cycle; out_valid high from the next cycle, latency 1):
//   - NaN operand, 0/0 or inf/inf -> QNAN.
//   - x/0 with x finite nonzero -> signed inf. inf/finite -> signed inf.
//   - 0/finite-nonzero or finite/inf -> signed zero.
// - Normal path, with ma={1,a[22:0]} and mb={1,b[22:0]}, both 24 bits:
//   - rem=ma; 25 iterations: bit = (rem>=mb); if bit then rem-=mb; rem<<=1; Q={Q[23:0],bit}.
//     rem is 25 bits wide.
//   - Q[24:0] = ma/mb with 24 fraction bits, so Q lies in (0.5, 2).
//   - NORM:
//     - Q[24]=1 -> frac=Q[23:1], e=ea-eb+127.
//     - Q[24]=0 -> frac=Q[22:0], e=ea-eb+126.
//   - e is computed as 10-bit signed. e>=255 -> signed inf. e<=0 -> signed zero (no denormal output).
//   - Rounding: truncation (round toward zero). Remainder is discarded.
// - Latency, normal path: out_valid is high in the 27th cycle after the accepting edge
//   (25 DIVIDE + 1 NORM + register). Latency is fixed and independent of operand values.
// - Output hold: while out_valid=1 and out_ready=0, q and out_valid are held stable.
// - in_ready=0 from the accept edge until the edge where out_valid & out_ready; one operation in flight.
// - out_valid & out_ready at an edge -> out_valid=0 and in_ready=1 after that edge.
//   A new accept occurs no earlier than the following edge.
// - in_valid while in_ready=0 is ignored. No buffering of the pending operand.
// TESTING
// - a=40000000 (2.0), b=3F800000 (1.0), out_ready=1 -> q=40000000; out_valid rises 27 cycles after accept.
// - a=3F800000, b=40000000 -> q=3F000000. a=C0C00000 (-6), b=40000000 -> q=C0400000.
// - a=3F800000, b=40400000 (1/3) -> q=3EAAAAAA (truncated, not 3EAAAAAB).
// - Specials, each at latency 1:
//   - 3F800000/00000000 -> 7F800000; 80000000/3F800000 -> 80000000.
//   - 00000000/00000000 -> 7FC00000; 7FC00001/3F800000 -> 7FC00000.
// - Range limits:
//   - 7F000000/3E800000 -> 7F800000 (overflow).
//   - 00800000/40000000 -> 00000000 (underflow flush).
// - Backpressure and reset:
//   - out_ready=0 for 10 cycles after out_valid: q and out_valid stable, in_ready=0, extra in_valid ignored.
//   - rst_n pulsed low mid-DIVIDE: out_valid=0 and in_ready=1 immediately; next op gives correct q.

Source files
------------

// File: rtl/fp_divider_seq_if.sv
// ---------------------------------------------------------------------------
// fp_divider_seq_if
// Handshake bundle for the sequential single-precision divider.
//   in_valid  / in_ready   : operand transfer (a, b), producer -> divider
//   out_valid / out_ready  : result transfer (q), divider -> consumer
// Modports:
//   master : the side that supplies operands and consumes the quotient
//   slave  : the divider itself
// ---------------------------------------------------------------------------
interface fp_divider_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] q;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q
  );
endinterface

// File: rtl/fp_divider_seq.sv
// ---------------------------------------------------------------------------
// fp_divider_seq
// Sequential IEEE-754 single-precision divider, q = a / b.
// The mantissa quotient comes from a restoring divider producing one bit per
// clock (25 bits, 24 of them fractional). Rounding is truncation, denormal
// inputs are flushed to signed zero, and no denormal results are produced.
// Special operands are resolved in the accept cycle (latency 1); the normal
// path always takes 25 DIVIDE + 1 NORM cycles (latency 27).
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : fp_divider_seq_if.slave (in_valid/in_ready/a/b, out_valid/out_ready/q)
// ---------------------------------------------------------------------------
module fp_divider_seq #(
  parameter logic [31:0] QNAN = 32'h7FC0_0000
) (
  input logic              clk,
  input logic              rst_n,
  fp_divider_seq_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_NORM, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic               r_sign;
  logic [24:0]        r_rem;
  logic [23:0]        r_mb;
  logic [24:0]        r_quo;
  logic [4:0]         r_cnt;
  logic signed [9:0]  r_exp;
  logic [31:0]        r_q;

  // Operand classification on the live inputs (only used in the accept cycle).
  logic [7:0]  w_ea, w_eb;
  logic        w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic        w_sign;
  logic        w_accept;
  logic        w_special;
  logic [31:0] w_special_q;

  assign w_ea     = bus.a[30:23];
  assign w_eb     = bus.b[30:23];
  assign w_a_zero = (w_ea == 8'd0);
  assign w_b_zero = (w_eb == 8'd0);
  assign w_a_inf  = (w_ea == 8'hFF) && (bus.a[22:0] == 23'd0);
  assign w_b_inf  = (w_eb == 8'hFF) && (bus.b[22:0] == 23'd0);
  assign w_a_nan  = (w_ea == 8'hFF) && (bus.a[22:0] != 23'd0);
  assign w_b_nan  = (w_eb == 8'hFF) && (bus.b[22:0] != 23'd0);
  assign w_sign   = bus.a[31] ^ bus.b[31];
  assign w_accept = bus.in_valid && (r_state == S_IDLE);

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_special   = 1'b1;
    w_special_q = QNAN;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_special_q = QNAN;
    end else if (w_b_zero || w_a_inf) begin
      w_special_q = {w_sign, 8'hFF, 23'd0};
    end else if (w_a_zero || w_b_inf) begin
      w_special_q = {w_sign, 31'd0};
    end else begin
      w_special = 1'b0;
    end
  end

  // One restoring step: since rem < 2*mb, the post-subtract value fits 24 bits
  // and the shift cannot overflow the 25-bit remainder.
  logic        w_bit;
  logic [24:0] w_rem_sub;

  assign w_bit     = (r_rem >= {1'b0, r_mb});
  assign w_rem_sub = w_bit ? (r_rem - {1'b0, r_mb}) : r_rem;

  // Normalisation: Q lies in (0.5, 2); Q[24] tells which side of 1.0.
  logic signed [9:0] w_exp_n;
  logic [22:0]       w_frac;
  logic [31:0]       w_norm_q;

  always_comb begin
    w_exp_n  = r_quo[24] ? r_exp : (r_exp - 10'sd1);
    w_frac   = r_quo[24] ? r_quo[23:1] : r_quo[22:0];
    w_norm_q = {r_sign, w_exp_n[7:0], w_frac};
    if (w_exp_n >= 10'sd255) begin
      w_norm_q = {r_sign, 8'hFF, 23'd0};
    end else if (w_exp_n <= 10'sd0) begin
      w_norm_q = {r_sign, 31'd0};
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = w_special ? S_DONE : S_DIVIDE;
      S_DIVIDE: if (r_cnt == 5'd0) w_state_nxt = S_NORM;
      S_NORM:   w_state_nxt = S_DONE;
      S_DONE:   if (bus.out_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers; reset clears everything so an aborted division
  // leaves no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign <= 1'b0;
      r_rem  <= '0;
      r_mb   <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_exp  <= '0;
      r_q    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sign <= w_sign;
            r_rem  <= {2'b01, bus.a[22:0]};
            r_mb   <= {1'b1, bus.b[22:0]};
            r_quo  <= '0;
            r_cnt  <= 5'd24;  // counts 24..0 -> 25 DIVIDE cycles
            r_exp  <= $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + 10'sd127;
            if (w_special) r_q <= w_special_q;
          end
        end
        S_DIVIDE: begin
          r_rem <= {w_rem_sub[23:0], 1'b0};
          r_quo <= {r_quo[23:0], w_bit};
          r_cnt <= r_cnt - 5'd1;
        end
        S_NORM:  r_q <= w_norm_q;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.q         = r_q;

endmodule

// File: tb/tb_fp_divider_seq.sv
// ---------------------------------------------------------------------------
// tb_fp_divider_seq
// Self-checking bench for fp_divider_seq: directed vectors with known answers,
// backpressure, reset mid-division, then randomized operands checked against
// an integer-arithmetic reference of the IEEE single divide (truncating).
// ---------------------------------------------------------------------------
module tb_fp_divider_seq;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fp_divider_seq_if bus ();

  fp_divider_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---- reference model -------------------------------------------------
  function automatic bit ref_special(input logic [31:0] a, input logic [31:0] b);
    return (a[30:23] == 8'd0) || (a[30:23] == 8'hFF) ||
           (b[30:23] == 8'd0) || (b[30:23] == 8'hFF);
  endfunction

  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic   s;
    int     ea, eb, e;
    bit     az, bz, ai, bi, an, bn;
    longint ma, mb, quo, frac;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    az = (ea == 0);
    bz = (eb == 0);
    ai = (ea == 255) && (a[22:0] == 23'd0);
    bi = (eb == 255) && (b[22:0] == 23'd0);
    an = (ea == 255) && !ai;
    bn = (eb == 255) && !bi;
    if (an || bn || (az && bz) || (ai && bi)) return 32'h7FC0_0000;
    if (bz || ai) return {s, 8'hFF, 23'd0};
    if (az || bi) return {s, 31'd0};
    ma  = longint'({1'b1, a[22:0]});
    mb  = longint'({1'b1, b[22:0]});
    quo = (ma << 24) / mb;            // ma/mb with 24 fraction bits, truncated
    e   = ea - eb + 127;
    if (quo >= (64'sd1 << 24)) begin
      frac = (quo >> 1) & 64'h7F_FFFF;
    end else begin
      frac = quo & 64'h7F_FFFF;
      e    = e - 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0)   return {s, 31'd0};
    return {s, 8'(e), 23'(frac)};
  endfunction

  // ---- one transaction -------------------------------------------------
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_q, input int exp_lat, input int stall);
    int          lat;
    logic [31:0] q_seen;
    @(negedge clk);
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.a         = a;
    bus.b         = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = (stall == 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = $urandom;   // must not affect the operation in flight
    bus.b        = $urandom;
    lat = 1;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".q"}, bus.q, exp_q);
    q_seen = bus.q;
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = 1'b1;     // ignored while busy
      bus.a        = $urandom;
      bus.b        = $urandom;
      @(posedge clk);
      #1;
      check({tag, ".hold_q"}, bus.q, q_seen);
      check({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, ".hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, ".drained_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, ".drained_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] sp [7];
    sp = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
           32'h7FC0_0001, 32'h0040_0000, 32'h3F80_0000};
    case ($urandom_range(0, 5))
      0:       return $urandom;
      4:       return sp[$urandom_range(0, 6)];
      5:       return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      default: return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
    endcase
  endfunction

  initial begin
    logic [31:0] ra, rb;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    #1;
    check("reset.in_ready", 32'(bus.in_ready), 32'd1);
    check("reset.out_valid", 32'(bus.out_valid), 32'd0);
    check("reset.q", bus.q, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed normal-path vectors (latency 27).
    run_op("two_by_one", 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 27, 0);
    run_op("one_by_two", 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 27, 0);
    run_op("neg_six",    32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 27, 0);
    run_op("third",      32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 27, 0);
    run_op("overflow",   32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 27, 0);
    run_op("underflow",  32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 27, 0);

    // Special cases (latency 1).
    run_op("x_by_zero",  32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1, 0);
    run_op("negz_by_x",  32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 1, 0);
    run_op("zero_zero",  32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1, 0);
    run_op("nan_op",     32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1, 0);
    run_op("inf_inf",    32'hFF80_0000, 32'h7F80_0000, 32'h7FC0_0000, 1, 0);
    run_op("x_by_ninf",  32'h4000_0000, 32'hFF80_0000, 32'h8000_0000, 1, 0);

    // Backpressure: result held for 10 cycles.
    run_op("backpressure", 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 27, 10);

    // Reset in the middle of DIVIDE.
    @(negedge clk);
    bus.a         = 32'h4000_0000;
    bus.b         = 32'h3F80_0000;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset.out_valid", 32'(bus.out_valid), 32'd0);
    check("midreset.in_ready", 32'(bus.in_ready), 32'd1);
    check("midreset.q", bus.q, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 27, 0);

    // Randomized operands against the reference model.
    for (int i = 0; i < 80; i++) begin
      ra = rand_operand();
      rb = rand_operand();
      run_op($sformatf("rand%0d", i), ra, rb, ref_div(ra, rb),
             ref_special(ra, rb) ? 1 : 27, ($urandom_range(0, 3) == 0) ? 2 : 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
